// File: rtl/vga_receiver.sv
// vga_receiver -- recovers pixel coordinates and frame timing from a VGA bus.
//
// Purpose: sink-side counterpart of the VGA output path. Samples HSYNC/VSYNC
// and RED/GRN/BLU on each px_ce strobe, measures line and frame lengths,
// locks after LOCK_FRAMES consecutive good frames and then re-emits the
// active-area pixels with their (x, y) coordinates.
//
// Optional feature: define FRAME_SUM_EN to build a 16-bit per-frame checksum
// of RED+GRN+BLU over all strobed pixels; otherwise frame_sum is tied to 0.
//
// Ports:
//   clk, rst         system clock, asynchronous active-high reset
//   px_ce            pixel sample strobe (one clk wide)
//   HSYNC, VSYNC     sync inputs, active level SYNC_POL
//   RED, GRN, BLU    10-bit colour components
//   pix_valid        one-clk strobe per active pixel while locked
//   x, y             active pixel column / line of the strobed pixel
//   rgb              {RED,GRN,BLU} of the strobed pixel
//   frame_start      one-clk pulse after each sampled vsync assertion
//   locked           timing lock achieved
//   err_cnt          lock-loss count, saturating at 255
//   frame_sum        per-frame checksum (0 unless FRAME_SUM_EN)
module vga_receiver #(
  parameter int H_ACTIVE    = 640,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int H_TOTAL     = 800,
  parameter int V_ACTIVE    = 480,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int V_TOTAL     = 525,
  parameter int SYNC_POL    = 0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        px_ce,
  input  logic        HSYNC,
  input  logic        VSYNC,
  input  logic [9:0]  RED,
  input  logic [9:0]  GRN,
  input  logic [9:0]  BLU,
  output logic        pix_valid,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic [29:0] rgb,
  output logic        frame_start,
  output logic        locked,
  output logic [7:0]  err_cnt,
  output logic [15:0] frame_sum
);

  localparam logic [9:0]  H_ST  = 10'(H_SYNC + H_BP);
  localparam logic [9:0]  H_EN  = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [9:0]  V_ST  = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  V_EN  = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [10:0] H_TOT = 11'(H_TOTAL);
  localparam logic [10:0] V_TOT = 11'(V_TOTAL);
  localparam logic [7:0]  LOCK_N = 8'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'd1023) ? v : v + 10'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'd255) ? v : v + 8'd1;
  endfunction

  state_t      state, state_nxt;
  logic [7:0]  good_cnt, good_nxt;
  logic        err_inc;
  logic        hs_p0, vs_p0;
  logic [9:0]  h_cnt, v_cnt, h_nxt, v_nxt;
  logic        line_bad;
  logic        hs_a, vs_a, hs_edge, vs_edge;
  logic [10:0] line_len, frame_len;
  logic        bad_line, frame_good, active;

  assign hs_a    = (HSYNC == SYNC_POL[0]);
  assign vs_a    = (VSYNC == SYNC_POL[0]);
  assign hs_edge = hs_a & ~hs_p0;
  assign vs_edge = vs_a & ~vs_p0;

  // Length of the line that ends at this hs edge.
  assign line_len = {1'b0, h_cnt} + 11'd1;
  // The vs edge coincides with the hs edge that closes the last line of the
  // frame, so that line is counted in the frame length.
  assign frame_len  = {1'b0, v_cnt} + 11'(hs_edge);
  assign bad_line   = hs_edge & (line_len != H_TOT);
  assign frame_good = (frame_len == V_TOT) & ~line_bad & ~bad_line;

  // Counter values for the current sample: h_nxt/v_nxt are the coordinates of
  // the pixel being sampled now (pixel 0 of a line coincides with its hs edge).
  assign h_nxt = hs_edge ? 10'd0 : sat_inc10(h_cnt);
  assign v_nxt = vs_edge ? 10'd0 : (hs_edge ? sat_inc10(v_cnt) : v_cnt);
  assign active = (h_nxt >= H_ST) && (h_nxt <= H_EN) &&
                  (v_nxt >= V_ST) && (v_nxt <= V_EN);

  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    err_inc   = 1'b0;
    if (px_ce) begin
      unique case (state)
        SEARCH: if (vs_edge) begin
          state_nxt = TRACK;
          good_nxt  = 8'd0;
        end
        TRACK: if (vs_edge) begin
          if (frame_good) begin
            good_nxt = good_cnt + 8'd1;
            if (good_cnt + 8'd1 >= LOCK_N) state_nxt = LOCKED;
          end else begin
            good_nxt = 8'd0;
          end
        end
        LOCKED: if ((vs_edge & ~frame_good) | bad_line) begin
          state_nxt = SEARCH;
          err_inc   = 1'b1;
        end
        default: state_nxt = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= SEARCH;
      good_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      good_cnt <= good_nxt;
    end
  end

  // Stage p0: sync history, counters, status; registered pixel outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_p0       <= 1'b0;
      vs_p0       <= 1'b0;
      h_cnt       <= 10'd0;
      v_cnt       <= 10'd0;
      line_bad    <= 1'b0;
      locked      <= 1'b0;
      err_cnt     <= 8'd0;
      frame_start <= 1'b0;
      pix_valid   <= 1'b0;
      x           <= 10'd0;
      y           <= 10'd0;
      rgb         <= 30'd0;
    end else begin
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      if (px_ce) begin
        hs_p0       <= hs_a;
        vs_p0       <= vs_a;
        h_cnt       <= h_nxt;
        v_cnt       <= v_nxt;
        line_bad    <= vs_edge ? 1'b0 : (line_bad | bad_line);
        locked      <= (state_nxt == LOCKED);
        frame_start <= vs_edge;
        if (err_inc) err_cnt <= sat_inc8(err_cnt);
        if (active && state_nxt == LOCKED) begin
          pix_valid <= 1'b1;
          x         <= h_nxt - H_ST;
          y         <= v_nxt - V_ST;
          rgb       <= {RED, GRN, BLU};
        end
      end
    end
  end

`ifdef FRAME_SUM_EN
  logic [15:0] acc;
  logic [15:0] pix_sum;

  assign pix_sum = 16'(rgb[29:20]) + 16'(rgb[19:10]) + 16'(rgb[9:0]);

  // Accumulator restarts at every vs edge so a partial frame never leaks into
  // the next checksum; the result is published only when the frame was locked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= 16'd0;
      frame_sum <= 16'd0;
    end else if (px_ce && vs_edge) begin
      acc <= 16'd0;
      if (state == LOCKED) frame_sum <= acc + (pix_valid ? pix_sum : 16'd0);
    end else if (pix_valid) begin
      acc <= acc + pix_sum;
    end
  end
`else
  assign frame_sum = 16'd0;
`endif

endmodule

// File: tb/tb_vga_receiver.sv
// Directed testbench for vga_receiver using a reduced 14x9 raster
// (8x4 active, 2-pixel hsync, 2-pixel back porch, 1-line vsync, 2-line back
// porch), active-low syncs, px_ce every second clk.
module tb_vga_receiver;

  localparam int HA = 8, HS = 2, HB = 2, HT = 14;
  localparam int VA = 4, VS = 1, VB = 2, VT = 9;

`ifdef FRAME_SUM_EN
  localparam logic [15:0] SUM_XYX   = 16'd272;  // 4*(2*28) + 8*(0+1+2+3)
  localparam logic [15:0] SUM_CONST = 16'd96;   // 32 pixels * 3
`else
  localparam logic [15:0] SUM_XYX   = 16'd0;
  localparam logic [15:0] SUM_CONST = 16'd0;
`endif

  logic        clk = 1'b0;
  logic        rst, px_ce, HSYNC, VSYNC;
  logic [9:0]  RED, GRN, BLU;
  logic        pix_valid, frame_start, locked;
  logic [9:0]  x, y;
  logic [29:0] rgb;
  logic [7:0]  err_cnt;
  logic [15:0] frame_sum;

  vga_receiver #(
    .H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HB), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_SYNC(VS), .V_BP(VB), .V_TOTAL(VT),
    .SYNC_POL(0), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .px_ce(px_ce), .HSYNC(HSYNC), .VSYNC(VSYNC),
    .RED(RED), .GRN(GRN), .BLU(BLU), .pix_valid(pix_valid), .x(x), .y(y),
    .rgb(rgb), .frame_start(frame_start), .locked(locked),
    .err_cnt(err_cnt), .frame_sum(frame_sum)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Colour mode: 0 -> {x,y,x} of the generator position, 1 -> constant 1,1,1.
  int         cmode = 0;
  int         strobes = 0;
  int         fs_cnt = 0;
  logic [9:0] fx, fy, lx, ly;

  // Inputs still hold the sampled pixel at the negedge where pix_valid is seen.
  always @(negedge clk) begin
    if (pix_valid) begin
      if (strobes == 0) begin
        fx = x;
        fy = y;
      end
      lx = x;
      ly = y;
      strobes++;
      chk("pix_rgb", 32'(rgb), 32'({RED, GRN, BLU}));
      if (cmode == 0) begin
        chk("pix_x", 32'(x), 32'(RED));
        chk("pix_y", 32'(y), 32'(GRN));
      end
    end
    if (frame_start) fs_cnt++;
  end

  // Sends one frame; short_v selects a line one pixel short, max_px >= 0
  // stops after that many pixels.
  task automatic send_frame(input int nlines, input int short_v, input int max_px);
    int n = 0;
    for (int v = 0; v < nlines; v++) begin
      for (int h = 0; h < ((v == short_v) ? HT - 1 : HT); h++) begin
        if (max_px >= 0 && n == max_px) return;
        @(negedge clk);
        HSYNC = (h < HS) ? 1'b0 : 1'b1;
        VSYNC = (v < VS) ? 1'b0 : 1'b1;
        if (h >= HS + HB && h < HS + HB + HA && v >= VS + VB && v < VS + VB + VA) begin
          RED = (cmode == 0) ? 10'(h - HS - HB) : 10'd1;
          GRN = (cmode == 0) ? 10'(v - VS - VB) : 10'd1;
          BLU = RED;
        end else begin
          RED = 10'd0;
          GRN = 10'd0;
          BLU = 10'd0;
        end
        px_ce = 1'b1;
        @(negedge clk);
        px_ce = 1'b0;
        n++;
      end
    end
  endtask

  int fs0;

  initial begin
    rst = 1'b1; px_ce = 1'b0; HSYNC = 1'b1; VSYNC = 1'b1;
    RED = 10'd0; GRN = 10'd0; BLU = 10'd0;
    repeat (3) @(negedge clk);
    chk("rst_pix_valid", 32'(pix_valid), 0);
    chk("rst_x", 32'(x), 0);
    chk("rst_y", 32'(y), 0);
    chk("rst_rgb", 32'(rgb), 0);
    chk("rst_frame_start", 32'(frame_start), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    chk("rst_frame_sum", 32'(frame_sum), 0);
    rst = 1'b0;

    // Lock acquisition: 3rd vs edge locks.
    send_frame(VT, -1, -1);
    send_frame(VT, -1, -1);
    chk("lock_after_2", 32'(locked), 0);
    send_frame(VT, -1, -1);
    chk("lock_after_3", 32'(locked), 1);
    chk("lock_err", 32'(err_cnt), 0);
    chk("lock_fs_cnt", 32'(fs_cnt), 3);

    // Full locked frame: raster extents and strobe count.
    strobes = 0;
    send_frame(VT, -1, -1);
    chk("frm_strobes", 32'(strobes), HA * VA);
    chk("frm_first_x", 32'(fx), 0);
    chk("frm_first_y", 32'(fy), 0);
    chk("frm_last_x", 32'(lx), HA - 1);
    chk("frm_last_y", 32'(ly), VA - 1);
    chk("sum_xyx", 32'(frame_sum), 32'(SUM_XYX));

    // Constant colour checksum (published at the following vs edge).
    cmode = 1;
    send_frame(VT, -1, -1);
    send_frame(VT, -1, -1);
    chk("sum_const", 32'(frame_sum), 32'(SUM_CONST));
    cmode = 0;

    // One short line at v=5: unlock at the next hs edge, no strobes after it.
    strobes = 0;
    send_frame(VT, 5, -1);
    chk("short_line_strobes", 32'(strobes), 3 * HA);
    chk("short_line_locked", 32'(locked), 0);
    chk("short_line_err", 32'(err_cnt), 1);
    strobes = 0;
    send_frame(VT, -1, -1);
    send_frame(VT, -1, -1);
    chk("short_line_no_pix", 32'(strobes), 0);
    chk("short_line_relock2", 32'(locked), 0);
    send_frame(VT, -1, -1);
    chk("short_line_relock3", 32'(locked), 1);

    // Short frame: unlocked at the closing vs edge.
    send_frame(VT - 1, -1, -1);
    chk("short_frame_still", 32'(locked), 1);
    chk("short_frame_err0", 32'(err_cnt), 1);
    send_frame(VT, -1, -1);
    chk("short_frame_unlock", 32'(locked), 0);
    chk("short_frame_err", 32'(err_cnt), 2);
    send_frame(VT, -1, -1);
    send_frame(VT, -1, -1);
    chk("short_frame_relock2", 32'(locked), 0);
    send_frame(VT, -1, -1);
    chk("short_frame_relock3", 32'(locked), 1);

    // Reset mid-line while locked and inside the active area.
    send_frame(VT, -1, 5 * HT + 6);
    rst = 1'b1;
    #1;
    chk("midrst_pix_valid", 32'(pix_valid), 0);
    chk("midrst_x", 32'(x), 0);
    chk("midrst_y", 32'(y), 0);
    chk("midrst_rgb", 32'(rgb), 0);
    chk("midrst_locked", 32'(locked), 0);
    chk("midrst_err", 32'(err_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    fs0 = fs_cnt;
    send_frame(VT, -1, -1);
    chk("midrst_fs", 32'(fs_cnt - fs0), 1);
    send_frame(VT, -1, -1);
    chk("midrst_relock2", 32'(locked), 0);
    strobes = 0;
    send_frame(VT, -1, -1);
    chk("midrst_relock3", 32'(locked), 1);
    chk("midrst_strobes", 32'(strobes), HA * VA);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
